// File: rtl/mem_port_arbiter.sv
// Two-master (instruction/data) arbiter onto a single-outstanding memory port.
// Requests are latched and address-translated when the arbiter is idle.
module mem_port_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAP_EN    = 1,
  parameter int unsigned DATA_PRIO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_ok,
  output logic            inst_stall,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [DW/8-1:0] data_be,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            data_ok,
  output logic            data_stall,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned BW = DW / 8;

  typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

  state_t          state, state_nx;
  logic            own_data, last_data;
  logic            req_wr;
  logic [BW-1:0]   req_be;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW-1:0]   inst_rdata_q, data_rdata_q;
  logic            any_req, pick_data;
  logic [AW-1:0]   sel_addr, sel_paddr;

  assign any_req = inst_req | data_req;
  // Round-robin tie goes to whoever was not served last.
  assign pick_data = data_req & (~inst_req | (DATA_PRIO != 0) | ~last_data);
  assign sel_addr  = pick_data ? data_addr : inst_addr;

  generate
    if (MAP_EN != 0 && AW == 32) begin : g_map
      always_comb begin
        sel_paddr = sel_addr;
        if (sel_addr[31:30] == 2'b10)
          sel_paddr = {3'b000, sel_addr[28:0]};
      end
    end else begin : g_nomap
      assign sel_paddr = sel_addr;
    end
  endgenerate

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req)    state_nx = ADDR;
      ADDR:    if (mem_gnt)    state_nx = RESP;
      RESP:    if (mem_rvalid) state_nx = DONE;
      DONE:                    state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_data     <= 1'b0;
      last_data    <= 1'b1;
      req_wr       <= 1'b0;
      req_be       <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        own_data  <= pick_data;
        last_data <= pick_data;
        req_wr    <= pick_data & data_wr;
        req_be    <= (pick_data && data_wr) ? data_be : '1;
        req_addr  <= sel_paddr;
        req_wdata <= pick_data ? data_wdata : '0;
      end
      if (state == RESP && mem_rvalid && !req_wr) begin
        if (own_data) data_rdata_q <= mem_rdata;
        else          inst_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_req    = (state == ADDR);
  assign mem_wr     = mem_req & req_wr;
  assign mem_be     = req_be;
  assign mem_addr   = req_addr;
  assign mem_wdata  = req_wdata;
  assign inst_ok    = (state == DONE) & ~own_data;
  assign data_ok    = (state == DONE) & own_data;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_stall = inst_req & ~inst_ok;
  assign data_stall = data_req & ~data_ok;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fixed-priority and round-robin instances
// share stimulus; one is selected for observation per sequence.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, data_wr, mem_gnt, mem_rvalid;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_be;

  logic [31:0] d_inst_rdata, d_data_rdata, d_mem_addr, d_mem_wdata;
  logic        d_inst_ok, d_inst_stall, d_data_ok, d_data_stall, d_mem_req, d_mem_wr;
  logic [3:0]  d_mem_be;
  logic [31:0] r_inst_rdata, r_data_rdata, r_mem_addr, r_mem_wdata;
  logic        r_inst_ok, r_inst_stall, r_data_ok, r_data_stall, r_mem_req, r_mem_wr;
  logic [3:0]  r_mem_be;

  logic [31:0] o_inst_rdata, o_data_rdata, o_mem_addr, o_mem_wdata;
  logic        o_inst_ok, o_inst_stall, o_data_ok, o_data_stall, o_mem_req, o_mem_wr;
  logic [3:0]  o_mem_be;

  bit          sel_rr = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_drd = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MAP_EN(1), .DATA_PRIO(1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(d_inst_rdata),
    .inst_ok(d_inst_ok), .inst_stall(d_inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(d_data_rdata), .data_ok(d_data_ok),
    .data_stall(d_data_stall),
    .mem_req(d_mem_req), .mem_wr(d_mem_wr), .mem_be(d_mem_be), .mem_addr(d_mem_addr),
    .mem_wdata(d_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MAP_EN(1), .DATA_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(r_inst_rdata),
    .inst_ok(r_inst_ok), .inst_stall(r_inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(r_data_rdata), .data_ok(r_data_ok),
    .data_stall(r_data_stall),
    .mem_req(r_mem_req), .mem_wr(r_mem_wr), .mem_be(r_mem_be), .mem_addr(r_mem_addr),
    .mem_wdata(r_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always_comb begin
    o_inst_rdata = sel_rr ? r_inst_rdata : d_inst_rdata;
    o_data_rdata = sel_rr ? r_data_rdata : d_data_rdata;
    o_mem_addr   = sel_rr ? r_mem_addr   : d_mem_addr;
    o_mem_wdata  = sel_rr ? r_mem_wdata  : d_mem_wdata;
    o_inst_ok    = sel_rr ? r_inst_ok    : d_inst_ok;
    o_inst_stall = sel_rr ? r_inst_stall : d_inst_stall;
    o_data_ok    = sel_rr ? r_data_ok    : d_data_ok;
    o_data_stall = sel_rr ? r_data_stall : d_data_stall;
    o_mem_req    = sel_rr ? r_mem_req    : d_mem_req;
    o_mem_wr     = sel_rr ? r_mem_wr     : d_mem_wr;
    o_mem_be     = sel_rr ? r_mem_be     : d_mem_be;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_drd = '0;
  endtask

  // Call with the request(s) already applied and the arbiter idle before the next edge.
  task automatic do_txn(input bit own_d, input logic [31:0] eaddr, input logic ewr,
                        input logic [3:0] ebe, input logic [31:0] ewdata, input int gwait,
                        input logic [31:0] rd, input bit keep, input bit scramble);
    @(posedge clk); #1;
    for (int i = 0; i <= gwait; i++) begin
      @(negedge clk);
      chk("addr_mem_req", {31'd0, o_mem_req}, 32'd1);
      chk("addr_mem_addr", o_mem_addr, eaddr);
      chk("addr_mem_wr", {31'd0, o_mem_wr}, {31'd0, ewr});
      chk("addr_mem_be", {28'd0, o_mem_be}, {28'd0, ebe});
      if (ewr) chk("addr_mem_wdata", o_mem_wdata, ewdata);
      chk("addr_inst_stall", {31'd0, o_inst_stall}, {31'd0, inst_req});
      chk("addr_data_stall", {31'd0, o_data_stall}, {31'd0, data_req});
      chk("addr_no_ok", {30'd0, o_inst_ok, o_data_ok}, 32'd0);
      if (scramble) begin
        data_addr = $urandom; data_wdata = $urandom; data_be = 4'($urandom);
      end
      if (i == gwait) begin
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      end
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
    end
    @(negedge clk);
    chk("resp_mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("resp_no_ok", {30'd0, o_inst_ok, o_data_ok}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("done_inst_ok", {31'd0, o_inst_ok}, {31'd0, !own_d});
    chk("done_data_ok", {31'd0, o_data_ok}, {31'd0, own_d});
    chk("done_mem_req", {31'd0, o_mem_req}, 32'd0);
    if (own_d) begin
      if (!ewr && !sel_rr) exp_drd = rd;
      chk("done_data_rdata", o_data_rdata, ewr ? exp_drd : rd);
      chk("done_data_stall", {31'd0, o_data_stall}, 32'd0);
      if (!keep) data_req = 1'b0;
    end else begin
      chk("done_inst_rdata", o_inst_rdata, rd);
      chk("done_inst_stall", {31'd0, o_inst_stall}, 32'd0);
      if (!keep) inst_req = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          is_data;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    int          gwait;
    bit          scr;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  initial begin
    vec[0] = '{1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0,         32'h2408_0001, 32'h1FC0_0000, 4'hF, 0, 1'b0};
    vec[1] = '{1'b1, 1'b1, 4'h3, 32'h8000_0010, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0010, 4'h3, 0, 1'b0};
    vec[2] = '{1'b1, 1'b0, 4'h5, 32'h0040_0000, 32'h0,         32'hA5A5_0F0F, 32'h0040_0000, 4'hF, 2, 1'b0};
    vec[3] = '{1'b0, 1'b0, 4'h0, 32'h9000_0004, 32'h0,         32'h1111_2222, 32'h1000_0004, 4'hF, 0, 1'b0};
    vec[4] = '{1'b1, 1'b1, 4'hC, 32'hC000_0008, 32'hCAFE_F00D, 32'h0,         32'hC000_0008, 4'hC, 5, 1'b1};
    vec[5] = '{1'b1, 1'b0, 4'h0, 32'hA000_0100, 32'h0,         32'h5555_AAAA, 32'h0000_0100, 4'hF, 1, 1'b0};
    vec[6] = '{1'b0, 1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0,         32'h0BAD_F00D, 32'h7FFF_FFFC, 4'hF, 0, 1'b0};
    vec[7] = '{1'b1, 1'b0, 4'h0, 32'hBFFF_FFFC, 32'h0,         32'h1357_9BDF, 32'h1FFF_FFFC, 4'hF, 0, 1'b0};
    vec[8] = '{1'b0, 1'b0, 4'h0, 32'h8000_0000, 32'h0,         32'h2468_ACE0, 32'h0000_0000, 4'hF, 0, 1'b0};

    rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_be = '0;
    inst_addr = '0; data_addr = '0; data_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_mem_wr", {31'd0, o_mem_wr}, 32'd0);
    chk("rst_ok", {30'd0, o_inst_ok, o_data_ok}, 32'd0);
    chk("rst_stall", {30'd0, o_inst_stall, o_data_stall}, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_inst_rdata", o_inst_rdata, 32'd0);
    chk("rst_data_rdata", o_data_rdata, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("idle_rvalid_ignored", {29'd0, o_inst_ok, o_data_ok, o_mem_req}, 32'd0);
      if (vec[k].is_data) begin
        data_req = 1'b1; data_wr = vec[k].wr; data_be = vec[k].be;
        data_addr = vec[k].addr; data_wdata = vec[k].wdata;
      end else begin
        inst_req = 1'b1; inst_addr = vec[k].addr;
      end
      do_txn(vec[k].is_data, vec[k].exp_addr, vec[k].is_data & vec[k].wr, vec[k].exp_be,
             vec[k].wdata, vec[k].gwait, vec[k].rd, 1'b0, vec[k].scr);
    end

    // Fixed priority: data first, then the held instruction request.
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    data_req = 1'b1; data_wr = 1'b0; data_be = '0; data_addr = 32'h8000_0020;
    do_txn(1'b1, 32'h0000_0020, 1'b0, 4'hF, 32'h0, 0, 32'h3333_4444, 1'b0, 1'b0);
    do_txn(1'b0, 32'h1FC0_0010, 1'b0, 4'hF, 32'h0, 1, 32'h5555_6666, 1'b0, 1'b0);

    // Round-robin under continuous requests: inst, data, inst.
    do_reset();
    sel_rr = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h8000_1000;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000;
    do_txn(1'b0, 32'h0000_1000, 1'b0, 4'hF, 32'h0, 0, 32'h0101_0101, 1'b1, 1'b0);
    do_txn(1'b1, 32'h0000_2000, 1'b0, 4'hF, 32'h0, 0, 32'h0202_0202, 1'b1, 1'b0);
    do_txn(1'b0, 32'h0000_1000, 1'b0, 4'hF, 32'h0, 0, 32'h0303_0303, 1'b0, 1'b0);
    data_req = 1'b0;
    sel_rr = 1'b0;

    // Reset during the address phase drops mem_req asynchronously.
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_mem_req", {31'd0, o_mem_req}, 32'd1);
    #1 rst = 1'b1;
    #1 chk("rst_addr_mem_req", {31'd0, o_mem_req}, 32'd0);
    inst_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset during the response phase: no ok, late rvalid ignored.
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b1; inst_req = 1'b0;
    #1;
    chk("rst_resp_ok", {30'd0, o_inst_ok, o_data_ok}, 32'd0);
    chk("rst_resp_mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_resp_mem_be", {28'd0, o_mem_be}, 32'd0);
    chk("rst_resp_data_rdata", o_data_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; exp_drd = '0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0001;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {29'd0, o_inst_ok, o_data_ok, o_mem_req}, 32'd0);
    end
    chk("post_rst_inst_rdata", o_inst_rdata, 32'd0);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    do_txn(1'b0, 32'h1FC0_0000, 1'b0, 4'hF, 32'h0, 0, 32'h2408_0001, 1'b0, 1'b0);
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_be = 4'h3;
    data_addr = 32'h8000_0010; data_wdata = 32'h1234_5678;
    do_txn(1'b1, 32'h0000_0010, 1'b1, 4'h3, 32'h1234_5678, 0, 32'h7777_7777, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
